bm_table_ctrl: RTL and testbench

Sequencer for the branch-metric table. On a start pulse it walks every (state, input) pair of the active trellis and drives the branch-metric unit's write enable and packed `i_mux` word, one pair per cycle, so the unit fills its distance memory. It then declares the table valid and gates received symbols into the decode datapath with a valid/ready handshake. It sits between the top-level control and the branch-metric unit, alongside the convolutional-encoder model that supplies the expected code word.

---
 rtl/param_def.sv | 27 ++
 rtl/bm_addr_cnt.sv | 56 +++++
 rtl/bm_table_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bm_table_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_def.sv
// ---------------------------------------------------------------------------
// param_def
// Shared constants and types for the branch-metric table sequencer:
//   - trellis dimensions (state count, radix, code-word width)
//   - FSM state encoding for bm_table_ctrl
//   - bit offsets of the fields packed into the branch-metric i_mux word
// ---------------------------------------------------------------------------
package param_def;

   localparam int MAX_STATE_NUM    = 256;    // trellis states
   localparam int RADIX            = 4;      // input symbols per state
   localparam int SLICED_INPUT_NUM = 6;      // code-word / received-symbol bits
   localparam int MAX_INPUT_NUM    = RADIX;  // distinct input symbols

   // Packed i_mux word: {input[15:14], state[13:6], symbol[5:0]}
   localparam int MUX_W         = 16;
   localparam int MUX_INPUT_LSB = 14;
   localparam int MUX_STATE_LSB = 6;
   localparam int MUX_SYM_LSB   = 0;

   typedef enum logic [1:0] {
      BM_IDLE  = 2'd0,
      BM_LOAD  = 2'd1,
      BM_READY = 2'd2
   } bm_ctrl_state_t;

endpackage : param_def

// File: rtl/bm_addr_cnt.sv
// ---------------------------------------------------------------------------
// bm_addr_cnt
// Nested (state, input) address counter for the table load. The input
// symbol is the fast digit; the state advances when the input wraps.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   i_clear        synchronous clear of both counters (wins over i_step)
//   i_step         advance one (state, input) pair
//   i_last_state   highest state index of the active trellis
//   o_state        current state index
//   o_input        current input symbol
//   o_last         current pair is the final one (last state, last symbol)
// ---------------------------------------------------------------------------
module bm_addr_cnt #(
   parameter int STATE_W = 8,
   parameter int RADIX_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clear,
   input  logic               i_step,
   input  logic [STATE_W-1:0] i_last_state,
   output logic [STATE_W-1:0] o_state,
   output logic [RADIX_W-1:0] o_input,
   output logic               o_last
);

   logic [STATE_W-1:0] r_state;
   logic [RADIX_W-1:0] r_input;
   logic               w_input_wrap;

   // Counters are power-of-two wide, so the all-ones symbol is RADIX-1.
   assign w_input_wrap = &r_input;
   assign o_last       = w_input_wrap && (r_state == i_last_state);
   assign o_state      = r_state;
   assign o_input      = r_input;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the always blocks are evaluated.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= '0;
         r_input <= '0;
      end else if (i_clear) begin
         r_state <= '0;
         r_input <= '0;
      end else if (i_step) begin
         r_input <= r_input + 1'b1;
         if (w_input_wrap) begin
            r_state <= r_state + 1'b1;
         end
      end
   end

endmodule : bm_addr_cnt

// File: rtl/bm_table_ctrl.sv
// ---------------------------------------------------------------------------
// bm_table_ctrl
// Sequencer for the branch-metric table. A start request sweeps every
// (state, input) pair of the active trellis, one write per cycle, driving
// the branch-metric unit's write enable and packed mux word. Once the sweep
// completes the table is flagged valid and received symbols are passed to
// the metric read port through a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_start         single-cycle (re)build request (ignored while loading)
//   i_last_state    highest active state, captured on an accepted start
//   i_enc_out       encoder code word for the current (o_state, o_input)
//   o_state/o_input current write address
//   o_mux           {o_input, o_state, i_enc_out} to the branch-metric unit
//   o_en_bm         table write enable
//   o_busy          load in progress
//   o_done          one-cycle pulse after the final write
//   o_table_valid   table contents usable
//   i_rx/i_rx_valid received symbol and its valid
//   o_rx_ready      symbol accepted (equals o_table_valid)
//   o_rx            registered symbol to the metric read port
//   o_dist_valid    one-cycle strobe qualifying o_rx
// ---------------------------------------------------------------------------
module bm_table_ctrl
   import param_def::*;
#(
   parameter int STATE_W = $clog2(MAX_STATE_NUM),
   parameter int RADIX_W = $clog2(MAX_INPUT_NUM),
   parameter int SYM_W   = SLICED_INPUT_NUM
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [STATE_W-1:0] i_last_state,
   input  logic [SYM_W-1:0]   i_enc_out,
   output logic [STATE_W-1:0] o_state,
   output logic [RADIX_W-1:0] o_input,
   output logic [MUX_W-1:0]   o_mux,
   output logic               o_en_bm,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_table_valid,
   input  logic [SYM_W-1:0]   i_rx,
   input  logic               i_rx_valid,
   output logic               o_rx_ready,
   output logic [SYM_W-1:0]   o_rx,
   output logic               o_dist_valid
);

   bm_ctrl_state_t     r_fsm;
   bm_ctrl_state_t     w_fsm_next;
   logic [STATE_W-1:0] r_last_state;
   logic               r_done;
   logic               r_table_valid;
   logic [SYM_W-1:0]   r_rx;
   logic               r_dist_valid;

   logic               w_start_acc;
   logic               w_load_end;
   logic               w_cnt_last;
   logic               w_cnt_step;
   logic               w_rx_fire;
   logic [MUX_W-1:0]   w_mux;

   // ---------------------------------------------------------------------
   // Address counter
   // ---------------------------------------------------------------------
   // Stepping stops on the final pair so the address holds after the load.
   assign w_cnt_step = (r_fsm == BM_LOAD) && !w_cnt_last;

   bm_addr_cnt #(
      .STATE_W (STATE_W),
      .RADIX_W (RADIX_W)
   ) u_addr_cnt (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_start_acc),
      .i_step       (w_cnt_step),
      .i_last_state (r_last_state),
      .o_state      (o_state),
      .o_input      (o_input),
      .o_last       (w_cnt_last)
   );

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_fsm_next  = r_fsm;
      w_start_acc = 1'b0;
      w_load_end  = 1'b0;
      unique case (r_fsm)
         BM_IDLE: begin
            if (i_start) begin
               w_fsm_next  = BM_LOAD;
               w_start_acc = 1'b1;
            end
         end
         BM_LOAD: begin
            if (w_cnt_last) begin
               w_fsm_next = BM_READY;
               w_load_end = 1'b1;
            end
         end
         BM_READY: begin
            if (i_start) begin
               w_fsm_next  = BM_LOAD;
               w_start_acc = 1'b1;
            end
         end
         default: w_fsm_next = BM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fsm         <= BM_IDLE;
         r_last_state  <= '0;
         r_done        <= 1'b0;
         r_table_valid <= 1'b0;
      end else begin
         r_fsm  <= w_fsm_next;
         r_done <= w_load_end;
         if (w_start_acc) begin
            r_last_state <= i_last_state;
         end
         if (w_load_end) begin
            r_table_valid <= 1'b1;
         end else if (w_start_acc) begin
            r_table_valid <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Received-symbol path
   // ---------------------------------------------------------------------
   // Ready is the registered table-valid flag, so a symbol offered in the
   // same cycle as a rebuild request is still accepted.
   assign w_rx_fire = i_rx_valid && r_table_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx         <= '0;
         r_dist_valid <= 1'b0;
      end else begin
         r_dist_valid <= w_rx_fire;
         if (w_rx_fire) begin
            r_rx <= i_rx;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_mux = '0;
      w_mux[MUX_INPUT_LSB +: RADIX_W] = o_input;
      w_mux[MUX_STATE_LSB +: STATE_W] = o_state;
      w_mux[MUX_SYM_LSB   +: SYM_W]   = i_enc_out;
   end

   assign o_mux         = w_mux;
   assign o_en_bm       = (r_fsm == BM_LOAD);
   assign o_busy        = (r_fsm == BM_LOAD);
   assign o_done        = r_done;
   assign o_table_valid = r_table_valid;
   assign o_rx_ready    = r_table_valid;
   assign o_rx          = r_rx;
   assign o_dist_valid  = r_dist_valid;

endmodule : bm_table_ctrl

// File: tb/tb_bm_table_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bm_table_ctrl
// Scoreboard bench for bm_table_ctrl: stimulus pushes expected table writes
// and expected received symbols into queues; a monitor on the falling edge
// pops and compares whenever the DUT asserts o_en_bm or o_dist_valid.
// ---------------------------------------------------------------------------
module tb_bm_table_ctrl;

   localparam int STATE_W = 8;
   localparam int RADIX_W = 2;
   localparam int SYM_W   = 6;

   typedef struct packed {
      logic [STATE_W-1:0] s;
      logic [RADIX_W-1:0] in;
   } wr_t;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               i_start = 1'b0;
   logic [STATE_W-1:0] i_last_state = '0;
   logic [SYM_W-1:0]   i_enc_out;
   logic [STATE_W-1:0] o_state;
   logic [RADIX_W-1:0] o_input;
   logic [15:0]        o_mux;
   logic               o_en_bm, o_busy, o_done, o_table_valid;
   logic [SYM_W-1:0]   i_rx = '0;
   logic               i_rx_valid = 1'b0;
   logic               o_rx_ready;
   logic [SYM_W-1:0]   o_rx;
   logic               o_dist_valid;

   int checks = 0;
   int errors = 0;

   wr_t              exp_wr[$];
   logic [SYM_W-1:0] exp_rx[$];

   int          cyc = 0;
   int          edge0 = 0;
   int          wr_seen = 0;
   int          done_at = 0;
   bit          done_seen = 1'b0;
   logic [15:0] last_mux = '0;

   always #5 clk = ~clk;

   // Encoder model: any fixed function of (state, input) will do.
   function automatic logic [SYM_W-1:0] enc_f(logic [STATE_W-1:0] s, logic [RADIX_W-1:0] in);
      return s[5:0] ^ {s[7:6], in, in};
   endfunction

   assign i_enc_out = enc_f(o_state, o_input);

   bm_table_ctrl #(
      .STATE_W (STATE_W),
      .RADIX_W (RADIX_W),
      .SYM_W   (SYM_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_last_state  (i_last_state),
      .i_enc_out     (i_enc_out),
      .o_state       (o_state),
      .o_input       (o_input),
      .o_mux         (o_mux),
      .o_en_bm       (o_en_bm),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_table_valid (o_table_valid),
      .i_rx          (i_rx),
      .i_rx_valid    (i_rx_valid),
      .o_rx_ready    (o_rx_ready),
      .o_rx          (o_rx),
      .o_dist_valid  (o_dist_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (o_en_bm) begin
         wr_seen++;
         check("wr_expected", (exp_wr.size() != 0), 1);
         if (exp_wr.size() != 0) begin
            wr_t e;
            e = exp_wr.pop_front();
            check("wr_state", o_state, e.s);
            check("wr_input", o_input, e.in);
            check("wr_mux", o_mux, {e.in, e.s, enc_f(e.s, e.in)});
         end
         check("wr_not_ready", {o_table_valid, o_rx_ready, o_busy}, 3'b001);
         last_mux = o_mux;
      end
      if (o_dist_valid) begin
         check("rx_expected", (exp_rx.size() != 0), 1);
         if (exp_rx.size() != 0) check("rx_value", o_rx, exp_rx.pop_front());
      end
      if (o_done) begin
         done_seen = 1'b1;
         done_at   = cyc - edge0 + 1;
         check("done_table_valid", o_table_valid, 1);
         check("done_writes_drained", exp_wr.size(), 0);
      end
   end

   task automatic push_writes(input int last);
      for (int s = 0; s <= last; s++)
         for (int in = 0; in < 4; in++)
            exp_wr.push_back('{s: STATE_W'(s), in: RADIX_W'(in)});
   endtask

   // Drives i_start for one cycle; returns #1 after edge 0.
   task automatic start_load(input int last);
      @(posedge clk); #1;
      i_start      = 1'b1;
      i_last_state = STATE_W'(last);
      push_writes(last);
      done_seen = 1'b0;
      wr_seen   = 0;
      @(posedge clk); #1;
      edge0   = cyc;
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_cycle, input int exp_writes);
      for (int n = 0; n < 3000 && !done_seen; n++) begin
         @(negedge clk); #1;
      end
      check({name, "_done_seen"}, done_seen, 1);
      check({name, "_done_cycle"}, done_at, exp_cycle);
      check({name, "_write_count"}, wr_seen, exp_writes);
      @(negedge clk); #1;
      check({name, "_done_pulse"}, o_done, 0);
      check({name, "_valid_held"}, o_table_valid, 1);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_state"}, o_state, 0);
      check({name, "_input"}, o_input, 0);
      check({name, "_en_bm"}, o_en_bm, 0);
      check({name, "_busy"}, o_busy, 0);
      check({name, "_done"}, o_done, 0);
      check({name, "_table_valid"}, o_table_valid, 0);
      check({name, "_rx_ready"}, o_rx_ready, 0);
      check({name, "_rx"}, o_rx, 0);
      check({name, "_dist_valid"}, o_dist_valid, 0);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SYM_W-1:0] syms [5];
      syms = '{6'h01, 6'h3E, 6'h15, 6'h2A, 6'h33};

      // Reset state
      #12;
      check_reset_outputs("reset");
      @(negedge clk); rst = 1'b1;

      // 1) last=3: 16 writes, done at cycle 17
      start_load(3);
      wait_done("load3", 17, 16);

      // 2) full sweep: 1024 writes, final mux[15:6]=0x3FF
      start_load(255);
      wait_done("load255", 1025, 1024);
      check("load255_last_addr", last_mux[15:6], 10'h3FF);

      // 3) i_start during LOAD cycle 5 is ignored
      start_load(3);
      repeat (4) @(posedge clk);
      #1;
      i_start      = 1'b1;
      i_last_state = 8'd200;
      @(posedge clk); #1;
      i_start = 1'b0;
      wait_done("ignore_start", 17, 16);

      // 4) receive path in READY
      @(posedge clk); #1;
      i_rx = 6'b101101; i_rx_valid = 1'b1;
      exp_rx.push_back(6'b101101);
      @(posedge clk); #1;
      i_rx_valid = 1'b0; i_rx = '0;
      @(negedge clk); #1;
      check("rx_latency", o_dist_valid, 1);
      @(negedge clk); #1;
      check("rx_strobe_once", o_dist_valid, 0);
      check("rx_hold", o_rx, 6'b101101);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         i_rx = syms[k]; i_rx_valid = 1'b1;
         exp_rx.push_back(syms[k]);
      end
      @(posedge clk); #1;
      i_rx_valid = 1'b0;
      @(negedge clk); #1;
      check("rx_stream_drained", exp_rx.size(), 0);

      // 6) i_start in READY: simultaneous symbol accepted, then refused
      @(posedge clk); #1;
      i_start = 1'b1; i_last_state = 8'd1;
      i_rx = 6'h27; i_rx_valid = 1'b1;
      exp_rx.push_back(6'h27);
      push_writes(1);
      done_seen = 1'b0;
      wr_seen   = 0;
      @(posedge clk); #1;
      edge0   = cyc;
      i_start = 1'b0;
      i_rx    = 6'h18;
      @(negedge clk); #1;
      check("reload_valid_drop", o_table_valid, 0);
      check("reload_ready_drop", o_rx_ready, 0);
      check("reload_simul_rx", o_dist_valid, 1);
      @(negedge clk); #1;
      check("reload_rx_refused", o_dist_valid, 0);
      check("reload_rx_kept", o_rx, 6'h27);
      @(posedge clk); #1;
      i_rx_valid = 1'b0;
      wait_done("reload", 9, 8);

      // 5) reset asserted in LOAD cycle 7
      start_load(3);
      repeat (6) @(posedge clk);
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("midload_rst");
      exp_wr.delete();
      wr_seen = 0;
      @(negedge clk); rst = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("idle_no_writes", wr_seen, 0);
      check("idle_not_busy", o_busy, 0);
      check("idle_not_valid", o_table_valid, 0);

      // recovery after reset
      start_load(3);
      wait_done("recover", 17, 16);

      check("final_wr_queue", exp_wr.size(), 0);
      check("final_rx_queue", exp_rx.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bm_table_ctrl
